// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Shares the common data bus between two ALUs completing Tomasulo
// instructions. Each ALU hands one result to its own slot through a
// valid/ready handshake. A round-robin arbiter picks one FULL slot per cycle
// and drives a registered CDB word.
//
// Handshake: a transfer happens on the rising clock edge where
// fuN_valid & fuN_ready are both 1. fuN_ready depends only on registered
// state (slot EMPTY, or slot granted this cycle), never on fuN_valid. The
// producer holds its payload stable while valid is high and ready is low.
//
// Ports:
//   clock            single clock, all state updates on posedge
//   reset            asynchronous, active-low, clears all state
//   flush            synchronous, drops both slots and the pending CDB word
//   fuN_valid/ready  per-ALU result handshake (N = 0, 1)
//   fuN_dest         one-hot destination register {R0,R1,R2}, R0 = MSB
//   fuN_tag          reservation-station position tag
//   fuN_data         result value
//   cdb              {dest, tag, unit_id, data}, zero when not broadcasting
//   cdb_valid        cdb carries a broadcast this cycle
//   bcast_count      broadcasts since reset, wraps
//   dbg_slot_state_o {slot1, slot0} state, 1 = FULL
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter  int DATA_W   = 10,
   parameter  int TAG_W    = 2,
   parameter  int NUM_REGS = 3,
   parameter  int CNT_W    = 8,
   localparam int CDB_W    = NUM_REGS + TAG_W + 1 + DATA_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   input  logic                fu0_valid,
   output logic                fu0_ready,
   input  logic [NUM_REGS-1:0] fu0_dest,
   input  logic [TAG_W-1:0]    fu0_tag,
   input  logic [DATA_W-1:0]   fu0_data,
   input  logic                fu1_valid,
   output logic                fu1_ready,
   input  logic [NUM_REGS-1:0] fu1_dest,
   input  logic [TAG_W-1:0]    fu1_tag,
   input  logic [DATA_W-1:0]   fu1_data,
   output logic [CDB_W-1:0]    cdb,
   output logic                cdb_valid,
   output logic [CNT_W-1:0]    bcast_count,
   output logic [1:0]          dbg_slot_state_o
);

   localparam int SLOT_W = NUM_REGS + TAG_W + DATA_W;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   slot_state_e       slot0_q, slot0_d;
   slot_state_e       slot1_q, slot1_d;
   logic [SLOT_W-1:0] slot0_pl_q, slot0_pl_d;
   logic [SLOT_W-1:0] slot1_pl_q, slot1_pl_d;
   logic              last_grant_q, last_grant_d;
   logic [CDB_W-1:0]  cdb_q, cdb_d;
   logic              cdb_valid_q, cdb_valid_d;
   logic [CNT_W-1:0]  bcast_count_q, bcast_count_d;

   logic              grant0, grant1;
   logic              cap0, cap1;

   // Arbitration uses registered slot state only. On a tie the unit that
   // did not win last time is granted.
   assign grant0 = (slot0_q == SLOT_FULL) &&
                   ((slot1_q != SLOT_FULL) || last_grant_q);
   assign grant1 = (slot1_q == SLOT_FULL) &&
                   ((slot0_q != SLOT_FULL) || !last_grant_q);

   // A granted slot empties on this edge, so it can take a new result at once.
   assign fu0_ready = (slot0_q == SLOT_EMPTY) || grant0;
   assign fu1_ready = (slot1_q == SLOT_EMPTY) || grant1;

   assign cap0 = fu0_valid && fu0_ready;
   assign cap1 = fu1_valid && fu1_ready;

   always_comb begin
      slot0_d       = slot0_q;
      slot1_d       = slot1_q;
      slot0_pl_d    = slot0_pl_q;
      slot1_pl_d    = slot1_pl_q;
      last_grant_d  = last_grant_q;
      cdb_d         = '0;
      cdb_valid_d   = 1'b0;
      bcast_count_d = bcast_count_q;

      if (flush) begin
         // Flush wins over capture and grant; arbitration history and the
         // broadcast count are kept.
         slot0_d = SLOT_EMPTY;
         slot1_d = SLOT_EMPTY;
      end else begin
         if (grant0) slot0_d = SLOT_EMPTY;
         if (cap0) begin
            slot0_d    = SLOT_FULL;
            slot0_pl_d = {fu0_dest, fu0_tag, fu0_data};
         end
         if (grant1) slot1_d = SLOT_EMPTY;
         if (cap1) begin
            slot1_d    = SLOT_FULL;
            slot1_pl_d = {fu1_dest, fu1_tag, fu1_data};
         end

         // Unit id is inserted between the tag and the data fields.
         if (grant0) begin
            cdb_d         = {slot0_pl_q[SLOT_W-1:DATA_W], 1'b0, slot0_pl_q[DATA_W-1:0]};
            cdb_valid_d   = 1'b1;
            last_grant_d  = 1'b0;
            bcast_count_d = bcast_count_q + CNT_W'(1);
         end else if (grant1) begin
            cdb_d         = {slot1_pl_q[SLOT_W-1:DATA_W], 1'b1, slot1_pl_q[DATA_W-1:0]};
            cdb_valid_d   = 1'b1;
            last_grant_d  = 1'b1;
            bcast_count_d = bcast_count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         slot0_q       <= SLOT_EMPTY;
         slot1_q       <= SLOT_EMPTY;
         slot0_pl_q    <= '0;
         slot1_pl_q    <= '0;
         last_grant_q  <= 1'b1;     // ALU0 wins the first tie
         cdb_q         <= '0;
         cdb_valid_q   <= 1'b0;
         bcast_count_q <= '0;
      end else begin
         slot0_q       <= slot0_d;
         slot1_q       <= slot1_d;
         slot0_pl_q    <= slot0_pl_d;
         slot1_pl_q    <= slot1_pl_d;
         last_grant_q  <= last_grant_d;
         cdb_q         <= cdb_d;
         cdb_valid_q   <= cdb_valid_d;
         bcast_count_q <= bcast_count_d;
      end
   end

   assign cdb              = cdb_q;
   assign cdb_valid        = cdb_valid_q;
   assign bcast_count      = bcast_count_q;
   assign dbg_slot_state_o = {slot1_q == SLOT_FULL, slot0_q == SLOT_FULL};

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter at default parameters. Expected CDB words
// are queued when a result is handed over and popped by a monitor when the
// DUT broadcasts.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flush;
   logic        fu0_valid, fu1_valid;
   logic        fu0_ready, fu1_ready;
   logic [2:0]  fu0_dest, fu1_dest;
   logic [1:0]  fu0_tag, fu1_tag;
   logic [9:0]  fu0_data, fu1_data;
   logic [15:0] cdb;
   logic        cdb_valid;
   logic [7:0]  bcast_count;
   logic [1:0]  dbg_slot_state;

   logic [15:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          pushed = 0;

   cdb_arbiter dut (
      .clock            (clock),
      .reset            (reset),
      .flush            (flush),
      .fu0_valid        (fu0_valid),
      .fu0_ready        (fu0_ready),
      .fu0_dest         (fu0_dest),
      .fu0_tag          (fu0_tag),
      .fu0_data         (fu0_data),
      .fu1_valid        (fu1_valid),
      .fu1_ready        (fu1_ready),
      .fu1_dest         (fu1_dest),
      .fu1_tag          (fu1_tag),
      .fu1_data         (fu1_data),
      .cdb              (cdb),
      .cdb_valid        (cdb_valid),
      .bcast_count      (bcast_count),
      .dbg_slot_state_o (dbg_slot_state)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // ---------------- helpers ----------------
   function automatic logic [15:0] mk(input logic [2:0] d, input logic [1:0] t,
                                      input logic u, input logic [9:0] x);
      return {d, t, u, x};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] w);
      exp_q.push_back(w);
      pushed++;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      flush     = 1'b0;
      fu0_valid = 1'b0;
      fu1_valid = 1'b0;
      fu0_dest  = '0;
      fu1_dest  = '0;
      fu0_tag   = '0;
      fu1_tag   = '0;
      fu0_data  = '0;
      fu1_data  = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      #1;
      check("rst_cdb", cdb, 0);
      check("rst_cdb_valid", cdb_valid, 0);
      check("rst_count", bcast_count, 0);
      exp_q.delete();
      pushed = 0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      tick();
      check("rst_ready0", fu0_ready, 1);
      check("rst_ready1", fu1_ready, 1);
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      forever begin
         @(posedge clock);
         #2;
         if (cdb_valid) begin
            if (exp_q.size() == 0) check("cdb_valid_spurious", cdb_valid, 0);
            else                   check("cdb_word", cdb, exp_q.pop_front());
         end else begin
            check("cdb_idle_zero", cdb, 0);
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      int          a, b, base;
      logic [2:0]  t4_dest[4];
      logic        r0e, r1e;

      t4_dest = '{3'b000, 3'b111, 3'b101, 3'b001};
      idle_inputs();

      // 1: single ALU0 result
      do_reset();
      fu0_valid = 1'b1; fu0_dest = 3'b010; fu0_tag = 2'b01; fu0_data = 10'd10;
      check("t1_fu0_ready", fu0_ready, 1);
      push(16'h480A);
      tick();
      fu0_valid = 1'b0;
      check("t1_no_bcast_yet", cdb_valid, 0);
      tick();
      check("t1_cdb_valid", cdb_valid, 1);
      check("t1_cdb", cdb, 16'h480A);
      check("t1_count", bcast_count, 1);
      tick();
      check("t1_idle_valid", cdb_valid, 0);
      check("t1_idle_cdb", cdb, 0);

      // 2: simultaneous first offer, ALU0 wins the tie after reset
      do_reset();
      fu0_valid = 1'b1; fu0_dest = 3'b100; fu0_tag = 2'b00; fu0_data = 10'd7;
      fu1_valid = 1'b1; fu1_dest = 3'b001; fu1_tag = 2'b10; fu1_data = 10'd5;
      push(mk(3'b100, 2'b00, 1'b0, 10'd7));
      push(16'h3405);
      tick();
      fu0_valid = 1'b0; fu1_valid = 1'b0;
      check("t2_fu1_waiting", fu1_ready, 0);
      check("t2_fu0_granted", fu0_ready, 1);
      tick();
      check("t2_first_unit", cdb[10], 0);
      check("t2_fu1_granted", fu1_ready, 1);
      tick();
      check("t2_second_word", cdb, 16'h3405);
      tick();
      check("t2_idle", cdb_valid, 0);

      // 3: both units saturating, grants alternate
      base = pushed;
      a = 0; b = 0;
      for (int i = 0; i < 8; i++) begin
         r0e = (i == 0) || (i % 2 == 1);
         r1e = (i % 2 == 0);
         fu0_valid = 1'b1; fu0_dest = 3'b100; fu0_tag = 2'(a); fu0_data = 10'(a);
         fu1_valid = 1'b1; fu1_dest = 3'b010; fu1_tag = 2'(b); fu1_data = 10'(10'h200 + b);
         check("t3_ready0", fu0_ready, r0e);
         check("t3_ready1", fu1_ready, r1e);
         if (r0e) begin push(mk(fu0_dest, fu0_tag, 1'b0, fu0_data)); a++; end
         if (r1e) begin push(mk(fu1_dest, fu1_tag, 1'b1, fu1_data)); b++; end
         tick();
         check("t3_count", bcast_count, 32'(base + i));
      end
      fu0_valid = 1'b0; fu1_valid = 1'b0;
      repeat (3) tick();
      check("t3_drained", exp_q.size(), 0);

      // 4: ALU1 streams alone; zero and multi-hot dest forwarded as is
      for (int i = 0; i < 4; i++) begin
         fu1_valid = 1'b1; fu1_dest = t4_dest[i]; fu1_tag = 2'(i); fu1_data = 10'(i + 1);
         check("t4_ready1", fu1_ready, 1);
         push(mk(fu1_dest, fu1_tag, 1'b1, fu1_data));
         tick();
         if (i > 0) check("t4_back_to_back", cdb_valid, 1);
      end
      fu1_valid = 1'b0;
      tick();
      check("t4_last_valid", cdb_valid, 1);
      tick();
      check("t4_idle", cdb_valid, 0);

      // 5: flush with both slots full, capture in the flush cycle is dropped
      fu0_valid = 1'b1; fu0_dest = 3'b001; fu0_tag = 2'b00; fu0_data = 10'h11;
      fu1_valid = 1'b1; fu1_dest = 3'b100; fu1_tag = 2'b11; fu1_data = 10'h22;
      tick();
      check("t5_both_full", dbg_slot_state, 2'b11);
      flush = 1'b1;
      fu0_valid = 1'b1; fu0_data = 10'h33;
      fu1_valid = 1'b0;
      tick();
      flush = 1'b0; fu0_valid = 1'b0;
      check("t5_flush_valid", cdb_valid, 0);
      check("t5_flush_cdb", cdb, 0);
      check("t5_ready0", fu0_ready, 1);
      check("t5_ready1", fu1_ready, 1);
      check("t5_count_kept", bcast_count, 32'(pushed));
      tick();
      check("t5_capture_dropped", cdb_valid, 0);
      fu0_valid = 1'b1; fu0_dest = 3'b010; fu0_tag = 2'b01; fu0_data = 10'h44;
      push(mk(fu0_dest, fu0_tag, 1'b0, fu0_data));
      tick();
      fu0_valid = 1'b0;
      tick();
      check("t5_after_flush", bcast_count, 32'(pushed));

      // 6: asynchronous reset mid-broadcast, then ALU0 wins the tie
      fu0_valid = 1'b1; fu0_dest = 3'b100; fu0_tag = 2'b01; fu0_data = 10'h55;
      fu1_valid = 1'b1; fu1_dest = 3'b001; fu1_tag = 2'b10; fu1_data = 10'h66;
      push(mk(3'b001, 2'b10, 1'b1, 10'h66));   // ALU0 won last, so ALU1 goes first
      tick();
      fu0_valid = 1'b0; fu1_valid = 1'b0;
      tick();
      check("t6_busy_valid", cdb_valid, 1);
      check("t6_slot0_full", dbg_slot_state, 2'b01);
      #3;
      reset = 1'b0;
      #1;
      check("t6_async_cdb", cdb, 0);
      check("t6_async_valid", cdb_valid, 0);
      check("t6_async_count", bcast_count, 0);
      check("t6_async_slots", dbg_slot_state, 2'b00);
      exp_q.delete();
      pushed = 0;
      @(negedge clock);
      reset = 1'b1;
      tick();
      fu0_valid = 1'b1; fu0_dest = 3'b010; fu0_tag = 2'b00; fu0_data = 10'h77;
      fu1_valid = 1'b1; fu1_dest = 3'b010; fu1_tag = 2'b01; fu1_data = 10'h88;
      push(mk(3'b010, 2'b00, 1'b0, 10'h77));
      push(mk(3'b010, 2'b01, 1'b1, 10'h88));
      tick();
      fu0_valid = 1'b0; fu1_valid = 1'b0;
      tick();
      check("t6_tie_unit0", cdb[10], 0);
      tick();
      check("t6_tie_unit1", cdb[10], 1);
      tick();

      // counter wrap after 256 broadcasts
      do_reset();
      for (int i = 0; i < 256; i++) begin
         fu0_valid = 1'b1; fu0_dest = 3'b001; fu0_tag = 2'(i); fu0_data = 10'(i);
         push(mk(fu0_dest, fu0_tag, 1'b0, fu0_data));
         tick();
      end
      fu0_valid = 1'b0;
      check("wrap_255", bcast_count, 255);
      tick();
      check("wrap_zero", bcast_count, 0);
      check("wrap_valid", cdb_valid, 1);
      tick();
      check("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the 16-bit common data bus (CDB) between the two functional units (ALU0, ALU1) that complete Tomasulo instructions.
- Each unit hands over one result through a valid/ready handshake and the result is held in a per-unit slot.
- A round-robin arbiter picks one slot per cycle and drives a registered CDB word.
- The CDB word feeds the register bank write enables and the reservation stations.

Parameters:
- DATA_W, 10, result data width.
- TAG_W, 2, reservation-station position tag width.
- NUM_REGS, 3, one-hot destination register width ({R0,R1,R2}, R0 = MSB).
- CNT_W, 8, width of the broadcast counter.
- CDB width is NUM_REGS+TAG_W+1+DATA_W, which is 16 at the defaults.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- flush  in  1  synchronous; discards pending results.
- fu0_valid  in  1  ALU0 offers a result.
- fu0_ready  out  1  ALU0 slot can accept this cycle.
- fu0_dest  in  NUM_REGS  one-hot destination register.
- fu0_tag  in  TAG_W  RS position.
- fu0_data  in  DATA_W  result.
- fu1_valid, fu1_ready, fu1_dest, fu1_tag, fu1_data: same as the fu0_* ports, for ALU1.
- cdb  out  16  {dest[15:13], tag[12:11], unit_id[10], data[9:0]}.
- cdb_valid  out  1  cdb carries a broadcast this cycle.
- bcast_count  out  CNT_W  total broadcasts since reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both slots EMPTY; cdb=0, cdb_valid=0, bcast_count=0.
  - last_grant=1, so ALU0 wins the first tie.
  - Effect is immediate, including mid-handshake or mid-broadcast; a captured but unbroadcast result is lost.
- Per-unit slot states: EMPTY, FULL.
- grant_N (combinational, from registered state only, never from fu*_valid):
  - One slot FULL: grant that slot.
  - Both slots FULL: grant the unit != last_grant.
  - Neither slot FULL: no grant.
- fuN_ready = (slot N EMPTY) | grant_N. This has no combinational path from fuN_valid.
- Capture: at posedge, if fuN_valid & fuN_ready, slot N <= {dest, tag, data} and stays FULL.
  - A granted slot can be refilled on the same edge, giving one result per cycle per unit when uncontended.
- Slot update at posedge: a granted slot that is not refilled goes EMPTY. A FULL slot that is not granted holds, even if fuN_valid=1 (ready=0).
- Broadcast at posedge:
  - If grant_N: cdb <= {slotN.dest, slotN.tag, N, slotN.data}, cdb_valid <= 1, last_grant <= N, bcast_count <= bcast_count+1 (wraps modulo 2^CNT_W).
  - Otherwise cdb <= 0 (all dest bits zero, so no register write) and cdb_valid <= 0.
- Latency: a result accepted at edge t appears on cdb after edge t+1 if uncontended, or after edge t+2 if it loses a tie.
- Max wait: with both units saturating, grants alternate 0,1,0,1; no unit waits more than 1 extra cycle.
- Dest pass-through: dest is forwarded unmodified.
  - dest=000: broadcast still occurs with cdb_valid=1 (RS wake-up only, no register write).
  - Multi-hot dest is forwarded as is.
- Flush at posedge (reset high):
  - Both slots become EMPTY, cdb <= 0, cdb_valid <= 0.
  - Captures in that cycle are discarded, so flush beats capture and grant.
  - last_grant and bcast_count are unchanged.
- Simultaneous first offer with both slots empty: both are captured at the same edge; ALU0 broadcasts first when last_grant=1.

Test Plan:
1. Reset then ALU0 offers dest=010, tag=01, data=10'd10 for one cycle -> fu0_ready=1; one cycle later cdb=16'h480A (0100_1000_0000_1010), cdb_valid=1, bcast_count=1; next cycle cdb=0, cdb_valid=0.
2. After reset both units offer in the same cycle: ALU0 {100,00,7}, ALU1 {001,10,5} -> cdb shows ALU0 word (bit10=0) then ALU1 word 16'h3405; fu1_ready=0 while waiting, 1 in the cycle ALU1 is granted.
3. Both units hold valid=1 continuously for 8 cycles with incrementing data -> cdb unit_id alternates 0,1,0,1…; no data lost or duplicated; bcast_count advances by 1 per cycle.
4. ALU1 alone streams data 1..4 on back-to-back cycles -> fu1_ready stays 1; cdb carries 1,2,3,4 on consecutive cycles.
5. Both slots FULL, pulse flush -> next cycle cdb_valid=0, both ready=1, bcast_count unchanged; a new ALU0 offer then broadcasts normally.
6. Assert reset low asynchronously between edges while cdb_valid=1 and a slot is FULL -> cdb=0, cdb_valid=0, bcast_count=0 immediately; after release ALU0 wins the first tie. Also run 256 broadcasts -> bcast_count wraps to 0.
